// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - opcode type and amount clamp shared by the shift engine
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_SAR  = 3'b110,
    OP_SHRS = 3'b111
  } shift_op_t;

  // Anything past the register width behaves like a full-width shift.
  function automatic int unsigned clamp_amt(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/shift_reg_param_shift_step.sv
// rtl/shift_reg_param_shift_step.sv - single-bit shift/rotate step for one opcode
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  shift_op_t        op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      OP_SHL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        out_bit    = value[WIDTH-1];
      end
      OP_SHR: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      OP_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_SAR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_SHRS: begin
        next_value = {serial_in, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: begin
        next_value = value;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - multi-bit shift/rotate engine, one bit per clock, valid/ready commands
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     AW          = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] data_q;
  logic             serial_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    cnt_q;
  shift_op_t        op_q;

  shift_op_t        cmd_op_e;
  shift_op_t        step_op;
  logic [AW-1:0]    amt_c;
  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] step_value;
  logic             step_bit;

  assign cmd_op_e  = shift_op_t'(cmd_op);
  assign cmd_ready = !busy_q;
  assign accept    = cmd_valid && cmd_ready && enable;
  assign amt_c     = AW'(clamp_amt(32'(cmd_amt), WIDTH));
  assign is_shift  = (cmd_op_e != OP_HOLD) && (cmd_op_e != OP_LOAD) && (amt_c != '0);
  // The accept edge performs step 1 using the incoming opcode; later steps use the latched one.
  assign step_op   = busy_q ? op_q : cmd_op_e;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (data_q),
    .op         (step_op),
    .serial_in  (serial_in),
    .next_value (step_value),
    .out_bit    (step_bit)
  );

  // cnt_q holds the number of steps still to perform after the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_HOLD;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (enable) begin
          data_q   <= step_value;
          serial_q <= step_bit;
          cnt_q    <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end else if (accept) begin
        op_q <= cmd_op_e;
        if (is_shift) begin
          data_q   <= step_value;
          serial_q <= step_bit;
          cnt_q    <= amt_c - AW'(1);
          busy_q   <= (amt_c != AW'(1));
          done_q   <= (amt_c == AW'(1));
        end else begin
          if (cmd_op_e == OP_LOAD) begin
            data_q <= data_in;
          end
          cnt_q  <= '0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign data_out   = data_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// tb/tb_shift_reg_param.sv - scoreboard bench for shift_reg_param
module tb_shift_reg_param;
  import shift_reg_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'b000;
  logic [AW-1:0] cmd_amt = '0;
  logic [W-1:0]  data_in = '0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  shift_reg_param dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_amt    (cmd_amt),
    .data_in    (data_in),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ser;
    bit         chk_ser;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc1, acc2, acc_x;
  logic [7:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_data", 32'(data_out), 32'(mon_e.data));
        if (mon_e.chk_ser) check("done_serial", 32'(serial_out), 32'(mon_e.ser));
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Leaves cmd_valid high on return (at the negedge after the accept edge).
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                       input bit push, input logic [7:0] ed, input logic es, input bit ces,
                       input int lat, output int acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    data_in   = din;
    for (int i = 0; i < 20 && !(cmd_ready && enable); i++) @(negedge clk);
    if (!(cmd_ready && enable)) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{ed, es, ces, acc + lat});
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_serial", 32'(serial_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    // Reset mid-SHL k=5 aborts without done
    issue(3'(OP_LOAD), 4'd0, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 0, acc_x);
    issue(3'(OP_SHL), 4'd5, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, acc_x);
    cmd_valid = 1'b0;
    check("shl_step1", 32'(data_out), 32'hFE);
    check("shl_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("shl_step2", 32'(data_out), 32'hFC);
    reset = 1'b1;
    #1;
    check("abort_data", 32'(data_out), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);

    // LOAD / ROL 1 / amt=0 / LOAD keeps serial_out
    issue(3'(OP_LOAD), 4'd0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 0, acc_x);
    check("load_busy", 32'(busy), 32'd0);
    issue(3'(OP_LOAD), 4'd0, 8'h81, 1'b1, 8'h81, 1'b0, 1'b0, 0, acc_x);
    issue(3'(OP_ROL), 4'd1, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 0, acc_x);
    check("rol_busy", 32'(busy), 32'd0);
    issue(3'(OP_SHL), 4'd0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 0, acc_x);
    issue(3'(OP_HOLD), 4'd7, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 0, acc_x);
    issue(3'(OP_LOAD), 4'd0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b1, 0, acc_x);

    // SAR 3 on 0x80
    issue(3'(OP_SAR), 4'd3, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b1, 2, acc_x);
    cmd_valid = 1'b0;
    check("sar_s1", 32'(data_out), 32'hC0);
    check("sar_busy1", 32'(busy), 32'd1);
    check("sar_ready1", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("sar_s2", 32'(data_out), 32'hE0);
    check("sar_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("sar_busy3", 32'(busy), 32'd0);

    // SHR 2 on 0x0F with a two-cycle stall after step 1
    issue(3'(OP_LOAD), 4'd0, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b1, 0, acc_x);
    issue(3'(OP_SHR), 4'd2, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 3, acc_x);
    cmd_valid = 1'b0;
    enable = 1'b0;
    check("shr_s1", 32'(data_out), 32'h07);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_data", 32'(data_out), 32'h07);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_serial", 32'(serial_out), 32'd1);
    end
    enable = 1'b1;
    @(negedge clk);
    wait_idle();

    // done drops even with enable low
    issue(3'(OP_LOAD), 4'd0, 8'h55, 1'b1, 8'h55, 1'b1, 1'b1, 0, acc_x);
    cmd_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("done_not_held", 32'(done), 32'd0);
    enable = 1'b1;

    // SHRS 8 with serial fill, then clamped SHL and ROR
    issue(3'(OP_LOAD), 4'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 0, acc_x);
    pat = 8'b0100_1101;
    serial_in = pat[0];
    issue(3'(OP_SHRS), 4'd8, 8'h00, 1'b1, 8'h4D, 1'b0, 1'b1, 7, acc_x);
    cmd_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      serial_in = pat[i];
      @(negedge clk);
    end
    wait_idle();
    issue(3'(OP_SHL), 4'd15, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 7, acc_x);
    cmd_valid = 1'b0;
    wait_idle();
    issue(3'(OP_LOAD), 4'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 0, acc_x);
    issue(3'(OP_ROR), 4'd9, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 7, acc_x);
    cmd_valid = 1'b0;
    wait_idle();

    // Back-to-back ROR 2 with cmd_valid held high
    issue(3'(OP_LOAD), 4'd0, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 0, acc_x);
    issue(3'(OP_ROR), 4'd2, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1, 1, acc1);
    check("b2b_s1", 32'(data_out), 32'h80);
    check("b2b_ready1", 32'(cmd_ready), 32'd0);
    issue(3'(OP_ROR), 4'd2, 8'h00, 1'b1, 8'h10, 1'b0, 1'b1, 1, acc2);
    check("b2b_no_bubble", acc2, acc1 + 2);
    check("b2b_s3", 32'(data_out), 32'h20);
    check("b2b_ready2", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
